// File: rtl/keypad_time_loader_if.sv
// Keypad-to-time-loader bus: encoder inputs, entry control and the loaded MM:SS buffer.
interface keypad_time_loader_if;
  logic        valid;
  logic [3:0]  BCD_in;
  logic        loadn;
  logic        clr_digits;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic        key_pulse;

  modport master (
    output valid, BCD_in, loadn, clr_digits,
    input  digits, digit_cnt, key_pulse
  );

  modport slave (
    input  valid, BCD_in, loadn, clr_digits,
    output digits, digit_cnt, key_pulse
  );
endinterface

// File: rtl/keypad_time_loader.sv
// Keypad time loader: synchronises and debounces encoder key presses and shifts
// each accepted BCD digit into a 4-digit MM:SS preset buffer.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no key down, waiting for a synchronised press
// DB_PRESS | press seen, counting stable-pressed cycles
// CAPTURE  | one cycle: sample BCD_in and shift it in if acceptable
// HOLD     | key still down; waits for release, never re-captures
// DB_REL   | release seen, counting stable-released cycles
module keypad_time_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input logic clk,
  input logic clearn,
  keypad_time_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    CAPTURE,
    HOLD,
    DB_REL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1, sync2;
  logic             press_s;
  logic             capture;
  logic             accept;
  logic [15:0]      digits_q;
  logic [2:0]       digit_cnt_q;

  // Two-stage synchroniser on the active-low encoder valid; resets to "released".
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.valid;
      sync2 <= sync1;
    end
  end

  assign press_s = ~sync2;

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: debounce press and release, capture exactly once per press.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (press_s) begin
          state_d = DB_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      DB_PRESS: begin
        if (!press_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        cnt_d = '0;
        if (!press_s) begin
          state_d = DB_REL;
          cnt_d   = CNT_ONE;
        end
      end
      DB_REL: begin
        if (press_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A clear in the capture cycle suppresses the digit and its strobe.
  assign accept = capture && (bus.BCD_in <= 4'd9) && !bus.loadn && !bus.clr_digits;

  // Digit shift buffer; the oldest digit drops off the top on overflow.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      digits_q    <= '0;
      digit_cnt_q <= '0;
    end else if (bus.clr_digits) begin
      digits_q    <= '0;
      digit_cnt_q <= '0;
    end else if (accept) begin
      digits_q <= {digits_q[11:0], bus.BCD_in};
      if (digit_cnt_q != 3'd4) begin
        digit_cnt_q <= digit_cnt_q + 3'd1;
      end
    end
  end

  assign bus.digits    = digits_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.key_pulse = accept;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Scoreboard bench for keypad_time_loader: stimulus pushes expected buffer
// contents and strobe timing; a monitor pops and compares on each key_pulse.
module tb_keypad_time_loader;

  localparam int D = 4;

  typedef struct {
    logic [15:0] digits;
    logic [2:0]  cnt;
    int          cyc;
  } exp_t;

  logic clk;
  logic clearn;
  int   cyc;
  int   checks;
  int   failures;
  int   n_pulses;
  exp_t exp_q[$];

  // Reference state: the MM:SS value as a number and the entered-digit count.
  logic [15:0] m_val;
  int          m_cnt;

  keypad_time_loader_if bus();

  keypad_time_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk    (clk),
    .clearn (clearn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: a digit becomes the new seconds-ones, everything shifts up one place.
  task automatic model_accept(input logic [3:0] d, input int t0);
    exp_t e;
    m_val = 16'((32'(m_val) * 16 + 32'(d)) % 65536);
    if (m_cnt < 4) m_cnt = m_cnt + 1;
    e.digits = m_val;
    e.cnt    = 3'(m_cnt);
    e.cyc    = t0 + 3 + D;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    m_val = 16'h0000;
    m_cnt = 0;
  endtask

  // One clean key press. hold >= D+4 keeps BCD_in stable through the capture cycle.
  task automatic press(input logic [3:0] d, input logic ld, input int hold, input int rel);
    int t0;
    @(posedge clk); #1;
    bus.BCD_in = d;
    bus.loadn  = ld;
    bus.valid  = 1'b0;
    t0 = cyc;
    if (d <= 4'd9 && !ld) model_accept(d, t0);
    repeat (hold) @(posedge clk);
    #1;
    bus.valid  = 1'b1;
    bus.BCD_in = 4'hF;
    repeat (rel) @(posedge clk);
    #1;
    bus.loadn = 1'b0;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1;
    bus.clr_digits = 1'b1;
    @(posedge clk); #1;
    bus.clr_digits = 1'b0;
    model_clear();
  endtask

  task automatic glitch(input logic [3:0] d, input int g);
    @(posedge clk); #1;
    bus.BCD_in = d;
    bus.valid  = 1'b0;
    repeat (g) @(posedge clk);
    #1;
    bus.valid  = 1'b1;
    bus.BCD_in = 4'hF;
    repeat (10) @(posedge clk);
  endtask

  // Monitor: every strobe must match the next expected entry in time and content.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.key_pulse === 1'b1) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=pulse_at_cycle_%0d required=no_pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          @(negedge clk);
          chk("digits_after_pulse", {16'h0, bus.digits}, {16'h0, e.digits});
          chk("cnt_after_pulse", {29'h0, bus.digit_cnt}, {29'h0, e.cnt});
        end
      end
    end
  end

  initial begin
    int p0, t0, wait_cnt;
    logic [3:0] d;
    checks   = 0;
    failures = 0;
    n_pulses = 0;
    model_clear();
    clearn         = 1'b0;
    bus.valid      = 1'b1;
    bus.BCD_in     = 4'hF;
    bus.loadn      = 1'b0;
    bus.clr_digits = 1'b0;
    #2;
    chk("reset_digits", {16'h0, bus.digits}, 32'h0);
    chk("reset_cnt", {29'h0, bus.digit_cnt}, 32'h0);
    chk("reset_pulse", {31'h0, bus.key_pulse}, 32'h0);
    repeat (3) @(posedge clk);
    #1 clearn = 1'b1;
    repeat (3) @(posedge clk);

    // 1: four clean presses
    p0 = n_pulses;
    press(4'd1, 1'b0, 10, 10);
    press(4'd2, 1'b0, 10, 10);
    press(4'd3, 1'b0, 10, 10);
    press(4'd0, 1'b0, 10, 10);
    chk("s1_digits", {16'h0, bus.digits}, 32'h1230);
    chk("s1_cnt", {29'h0, bus.digit_cnt}, 32'd4);
    chk("s1_pulses", n_pulses - p0, 4);

    // 2: long hold yields a single digit
    clear_pulse();
    chk("clr_digits", {16'h0, bus.digits}, 32'h0);
    chk("clr_cnt", {29'h0, bus.digit_cnt}, 32'h0);
    p0 = n_pulses;
    press(4'd5, 1'b0, 50, 10);
    chk("s2_digits", {16'h0, bus.digits}, 32'h0005);
    chk("s2_pulses", n_pulses - p0, 1);

    // 3: bounce low2/high1/low2 produces nothing
    p0 = n_pulses;
    @(posedge clk); #1;
    bus.BCD_in = 4'd9;
    bus.valid = 1'b0;
    repeat (2) @(posedge clk); #1 bus.valid = 1'b1;
    @(posedge clk); #1 bus.valid = 1'b0;
    repeat (2) @(posedge clk); #1 bus.valid = 1'b1;
    bus.BCD_in = 4'hF;
    repeat (15) @(posedge clk);
    chk("s3_pulses", n_pulses - p0, 0);
    chk("s3_digits", {16'h0, bus.digits}, 32'h0005);

    // 4: overflow drops the oldest digit
    clear_pulse();
    for (int i = 1; i <= 5; i++) press(4'(i), 1'b0, 10, 10);
    chk("s4_digits", {16'h0, bus.digits}, 32'h2345);
    chk("s4_cnt", {29'h0, bus.digit_cnt}, 32'd4);

    // 5: locked entry ignored, then unlocked entry accepted
    p0 = n_pulses;
    press(4'd7, 1'b1, 12, 10);
    chk("s5_locked_pulses", n_pulses - p0, 0);
    chk("s5_locked_digits", {16'h0, bus.digits}, 32'h2345);
    press(4'd8, 1'b0, 12, 10);
    chk("s5_digits", {16'h0, bus.digits}, 32'h3458);

    // 6a: clear coinciding with the capture cycle
    p0 = n_pulses;
    @(posedge clk); #1;
    bus.BCD_in = 4'd6;
    bus.valid = 1'b0;
    repeat (3 + D) @(posedge clk);
    #1 bus.clr_digits = 1'b1;
    @(posedge clk); #1 bus.clr_digits = 1'b0;
    model_clear();
    repeat (6) @(posedge clk);
    #1 bus.valid = 1'b1;
    bus.BCD_in = 4'hF;
    repeat (12) @(posedge clk);
    chk("s6_clr_pulses", n_pulses - p0, 0);
    chk("s6_clr_digits", {16'h0, bus.digits}, 32'h0);
    chk("s6_clr_cnt", {29'h0, bus.digit_cnt}, 32'h0);

    // 6b: async reset mid-press; a still-held key is a fresh press afterwards
    press(4'd4, 1'b0, 10, 10);
    @(posedge clk); #1;
    bus.BCD_in = 4'd2;
    bus.valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 clearn = 1'b0;
    #1;
    chk("s6_rst_digits", {16'h0, bus.digits}, 32'h0);
    chk("s6_rst_cnt", {29'h0, bus.digit_cnt}, 32'h0);
    chk("s6_rst_pulse", {31'h0, bus.key_pulse}, 32'h0);
    model_clear();
    @(posedge clk); #1;
    clearn = 1'b1;
    t0 = cyc;
    model_accept(4'd2, t0);
    repeat (12) @(posedge clk);
    #1 bus.valid = 1'b1;
    bus.BCD_in = 4'hF;
    repeat (12) @(posedge clk);
    chk("s6_rst_repress", {16'h0, bus.digits}, 32'h0002);

    // Randomised presses, locked presses, invalid codes and short glitches
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        glitch(4'($urandom_range(0, 9)), int'($urandom_range(1, D - 1)));
      end else begin
        if ($urandom_range(0, 4) == 0) d = 4'($urandom_range(10, 15));
        else d = 4'($urandom_range(0, 9));
        press(d, 1'($urandom_range(0, 4) == 0),
              int'($urandom_range(D + 6, 30)), int'($urandom_range(D + 6, 20)));
      end
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain_expected_pulses", exp_q.size(), 0);
    chk("final_digits", {16'h0, bus.digits}, {16'h0, m_val});
    chk("final_cnt", {29'h0, bus.digit_cnt}, 32'(m_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
